// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 2-digit 7-segment scan display.
//   Segment patterns are {g,f,e,d,c,b,a}, bit0 = a, active-high.
//   Digit enables are one-hot: bit0 = ones digit, bit1 = tens digit.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_OFF  = 2'b00;
  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;

  // Which digit the scan is currently serving.
  typedef enum logic {
    SLOT_ONES = 1'b0,
    SLOT_TENS = 1'b1
  } slot_e;

  // Applies pin polarity to an active-high segment pattern.
  function automatic logic [6:0] seg_polarity(input logic [6:0] seg_hi,
                                              input logic       active_low);
    return active_low ? ~seg_hi : seg_hi;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to 7-segment pattern decoder.
//   nibble : 4-bit BCD digit in
//   seg    : active-high {g,f,e,d,c,b,a}; codes 10..15 show a dash (g only)
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan2.sv
// seg7_scan2: time-multiplexed driver for a common-segment 2-digit
// 7-segment display fed by a packed 2-digit BCD counter.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   bcd_in : [7:4] tens, [3:0] ones; sampled only at frame boundaries
//   lzb    : blank the tens digit when it is zero (live, not captured)
//   seg    : registered segment pattern {g,f,e,d,c,b,a}
//   dig    : registered one-hot digit enable, bit0 = ones, bit1 = tens
//   frame  : registered one-cycle pulse following each bcd_in capture
module seg7_scan2
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned BLANK_GAP      = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bcd_in,
  input  logic       lzb,
  output logic [6:0] seg,
  output logic [1:0] dig,
  output logic       frame
);

  localparam int unsigned    CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic           ACT_LOW  = (SEG_ACTIVE_LOW != 0);
  localparam logic           GAP_EN   = (BLANK_GAP != 0);
  // Pin level of an unlit digit.
  localparam logic [6:0]     SEG_IDLE = ACT_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_e            sel_q, sel_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       dig_q, dig_d;
  logic             frame_q, frame_d;

  logic             wrap;
  logic             capture;
  logic             gap;
  logic             lz_blank;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic [6:0]       seg_hi;

  // Scan timing and frame capture.
  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    // The frame ends when the tens slot finishes; capturing here keeps
    // both digits of one frame showing the same count.
    capture  = wrap && (sel_q == SLOT_TENS);
    cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
    sel_d    = sel_q;
    if (wrap) begin
      sel_d = (sel_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
    end
    shadow_d = capture ? bcd_in : shadow_q;
    frame_d  = capture;
  end

  assign nibble = (sel_q == SLOT_TENS) ? shadow_q[7:4] : shadow_q[3:0];

  bcd_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Digit enable, blanking and pin polarity.
  always_comb begin
    // First cycle of each slot is dark so the previous digit's segments
    // cannot ghost onto the newly enabled digit.
    gap      = GAP_EN && (cnt_q == '0);
    lz_blank = (sel_q == SLOT_TENS) && lzb && (shadow_q[7:4] == 4'd0);

    dig_d  = (sel_q == SLOT_TENS) ? DIG_TENS : DIG_ONES;
    seg_hi = glyph;
    if (lz_blank) begin
      seg_hi = SEG_BLANK;
    end
    if (gap) begin
      dig_d  = DIG_OFF;
      seg_hi = SEG_BLANK;
    end
    seg_d = seg_polarity(seg_hi, ACT_LOW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      sel_q    <= SLOT_ONES;
      shadow_q <= 8'h00;
      seg_q    <= SEG_IDLE;
      dig_q    <= DIG_OFF;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      frame_q  <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dig   = dig_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan2.sv
// tb_seg7_scan2: bench for seg7_scan2 with three instances sharing inputs:
//   u_a SCAN_DIV=4 gap on, active-high; u_b same but active-low;
//   u_c SCAN_DIV=2 no gap, active-high.
module tb_seg7_scan2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] bcd_in;
  logic       lzb;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] dig_a, dig_b, dig_c;
  logic       frame_a, frame_b, frame_c;

  seg7_scan2 #(.SCAN_DIV(4), .BLANK_GAP(1), .SEG_ACTIVE_LOW(0)) u_a (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .lzb(lzb),
    .seg(seg_a), .dig(dig_a), .frame(frame_a));

  seg7_scan2 #(.SCAN_DIV(4), .BLANK_GAP(1), .SEG_ACTIVE_LOW(1)) u_b (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .lzb(lzb),
    .seg(seg_b), .dig(dig_b), .frame(frame_b));

  seg7_scan2 #(.SCAN_DIV(2), .BLANK_GAP(0), .SEG_ACTIVE_LOW(0)) u_c (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .lzb(lzb),
    .seg(seg_c), .dig(dig_c), .frame(frame_c));

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  int         n_checks = 0;
  int         n_fail   = 0;
  int         k        = 0;     // clock edges since reset release
  logic [7:0] sh4      = 8'h00; // value shown by the SCAN_DIV=4 instances
  logic [7:0] sh2      = 8'h00; // value shown by the SCAN_DIV=2 instance

  typedef struct {
    logic [7:0] bcd;
    bit         lz;
    bit         tens;
    logic [6:0] exp_seg;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  // Display seen right after edge kk: the edge-kk-1 cycle position within
  // a 2*d frame decides slot and gap; sh is the value captured last frame.
  function automatic logic [8:0] model(input int d, input bit gap_en,
                                       input bit al, input int kk,
                                       input logic [7:0] sh, input bit lz);
    int         pos;
    bit         tens;
    logic [3:0] digit;
    logic [6:0] s;
    logic [1:0] dg;
    pos   = (kk - 1) % (2 * d);
    tens  = (pos >= d);
    digit = tens ? sh[7:4] : sh[3:0];
    s     = GLYPH[digit];
    dg    = tens ? 2'b10 : 2'b01;
    if (tens && lz && sh[7:4] == 4'd0) s = 7'h00;
    if (gap_en && (pos % d) == 0) begin
      s  = 7'h00;
      dg = 2'b00;
    end
    if (al) s = ~s;
    return {dg, s};
  endfunction

  task automatic tick();
    logic [8:0] ea, eb, ec;
    bit         fa, fc;
    @(posedge clk);
    k++;
    ea = model(4, 1'b1, 1'b0, k, sh4, lzb);
    eb = model(4, 1'b1, 1'b1, k, sh4, lzb);
    ec = model(2, 1'b0, 1'b0, k, sh2, lzb);
    fa = (k % 8 == 0);
    fc = (k % 4 == 0);
    if (fa) sh4 = bcd_in;
    if (fc) sh2 = bcd_in;
    @(negedge clk);
    check("a_seg", seg_a, ea[6:0]);
    check("a_dig", dig_a, ea[8:7]);
    check("a_frame", frame_a, fa);
    check("b_seg", seg_b, eb[6:0]);
    check("b_dig", dig_b, eb[8:7]);
    check("b_frame", frame_b, fa);
    check("c_seg", seg_c, ec[6:0]);
    check("c_dig", dig_c, ec[8:7]);
    check("c_frame", frame_c, fc);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called just after a falling edge; reset clears without any clock edge.
  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    check("rst_a_seg", seg_a, 7'h00);
    check("rst_a_dig", dig_a, 2'b00);
    check("rst_a_frame", frame_a, 1'b0);
    check("rst_b_seg", seg_b, 7'h7F);
    check("rst_b_dig", dig_b, 2'b00);
    check("rst_c_seg", seg_c, 7'h00);
    check("rst_c_frame", frame_c, 1'b0);
    k   = 0;
    sh4 = 8'h00;
    sh2 = 8'h00;
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_dig [8];
    logic [6:0] exp_seg [8];

    reset  = 1'b1;
    bcd_in = 8'h00;
    lzb    = 1'b0;

    vecs[0]  = '{8'h47, 1'b0, 1'b0, 7'h07};
    vecs[1]  = '{8'h47, 1'b0, 1'b1, 7'h66};
    vecs[2]  = '{8'h05, 1'b1, 1'b1, 7'h00};
    vecs[3]  = '{8'h05, 1'b1, 1'b0, 7'h6D};
    vecs[4]  = '{8'h05, 1'b0, 1'b1, 7'h3F};
    vecs[5]  = '{8'hA3, 1'b0, 1'b1, 7'h40};
    vecs[6]  = '{8'hA3, 1'b0, 1'b0, 7'h4F};
    vecs[7]  = '{8'h19, 1'b0, 1'b1, 7'h06};
    vecs[8]  = '{8'h19, 1'b1, 1'b0, 7'h6F};
    vecs[9]  = '{8'hF0, 1'b1, 1'b1, 7'h40};
    vecs[10] = '{8'h00, 1'b1, 1'b1, 7'h00};
    vecs[11] = '{8'h00, 1'b1, 1'b0, 7'h3F};
    vecs[12] = '{8'h88, 1'b0, 1'b0, 7'h7F};
    vecs[13] = '{8'h62, 1'b0, 1'b1, 7'h7D};

    @(negedge clk);
    do_reset();

    // Scan pattern straight out of reset with a zero count.
    exp_dig = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
    exp_seg = '{7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h00, 7'h3F, 7'h3F, 7'h3F};
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t1_dig", dig_a, exp_dig[i]);
      check("t1_seg", seg_a, exp_seg[i]);
    end
    check("t1_frame", frame_a, 1'b1);

    // Table vectors: capture one value, then look at the chosen slot.
    for (int v = 0; v < 14; v++) begin
      do_reset();
      bcd_in = vecs[v].bcd;
      lzb    = vecs[v].lz;
      ticks(vecs[v].tens ? 15 : 11);
      check("vec_seg", seg_a, vecs[v].exp_seg);
      check("vec_dig", dig_a, vecs[v].tens ? 2'b10 : 2'b01);
    end
    lzb = 1'b0;

    // Tearing guard: input changes halfway through the tens slot.
    do_reset();
    bcd_in = 8'h19;
    ticks(14);
    bcd_in = 8'h20;
    tick();
    check("tear_tens_hold", seg_a, 7'h06);
    tick();
    check("tear_tens_last", seg_a, 7'h06);
    ticks(2);
    check("tear_ones_new", seg_a, 7'h3F);
    ticks(4);
    check("tear_tens_new", seg_a, 7'h5B);

    // Mid-slot reset restarts the scan from the ones slot with shadow 00.
    bcd_in = 8'h77;
    ticks(3);
    do_reset();
    tick();
    check("mid_rst_gap", dig_a, 2'b00);
    tick();
    check("mid_rst_dig", dig_a, 2'b01);
    check("mid_rst_seg", seg_a, 7'h3F);

    // Active-low pins.
    do_reset();
    bcd_in = 8'h11;
    ticks(9);
    check("al_blank", seg_b, 7'h7F);
    tick();
    check("al_one", seg_b, 7'h79);

    // Upstream counter stepping 08 -> 09 -> 10, one step per frame.
    do_reset();
    bcd_in = 8'h08;
    ticks(4);
    bcd_in = 8'h09;
    ticks(2);
    check("cnt_08_ones", seg_c, 7'h7F);
    ticks(2);
    bcd_in = 8'h10;
    ticks(2);
    check("cnt_09_ones", seg_c, 7'h6F);
    ticks(3);
    check("cnt_10_ones", seg_c, 7'h3F);
    check("cnt_10_dig0", dig_c, 2'b01);
    ticks(2);
    check("cnt_10_tens", seg_c, 7'h06);
    check("cnt_10_dig1", dig_c, 2'b10);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bcd_in = 8'($urandom_range(0, 255));
      lzb    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) do_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Absolute bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
